// File: rtl/alu_issue_if.sv
// Bundle of the instruction handshake, load port, ALU operand/result
// and writeback signals that run between the issue controller and
// its surroundings.
interface alu_issue_if #(
   parameter int WIDTH = 8
) ();
   logic             instr_valid;
   logic             instr_ready;
   logic [7:0]       instr;
   logic             ld_en;
   logic [1:0]       ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic             ld_ready;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_sel;
   logic [WIDTH-1:0] alu_out;
   logic             wb_valid;
   logic [1:0]       wb_addr;
   logic [WIDTH-1:0] wb_data;
   logic             busy;

   // Environment side: issues instructions and loads, models the ALU.
   modport master (
      output instr_valid, instr, ld_en, ld_addr, ld_data, alu_out,
      input  instr_ready, ld_ready, alu_a, alu_b, alu_sel,
             wb_valid, wb_addr, wb_data, busy
   );

   // Controller side.
   modport slave (
      input  instr_valid, instr, ld_en, ld_addr, ld_data, alu_out,
      output instr_ready, ld_ready, alu_a, alu_b, alu_sel,
             wb_valid, wb_addr, wb_data, busy
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback controller for an external combinational
// ALU. Holds a small register file, accepts one instruction at a time,
// presents registered operands for a settle cycle, captures the ALU
// result and writes it back. A side port loads registers directly.
module alu_issue_ctrl #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input logic   clk,
   input logic   rst,
   alu_issue_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      WB      = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [1:0]       rd_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [1:0]       alu_sel_q;

   logic [1:0] op;
   logic [1:0] rd;
   logic [1:0] rs1;
   logic [1:0] rs2;
   logic       accept;

   assign op  = bus.instr[7:6];
   assign rd  = bus.instr[5:4];
   assign rs1 = bus.instr[3:2];
   assign rs2 = bus.instr[1:0];

   // An instruction is taken only while idle and out of reset.
   assign accept = (state_q == IDLE) && bus.instr_valid && !rst;

   // State register.
   // NOTE: every clocked block uses non-blocking assignments so all
   // registers update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: a fixed four-cycle walk once an instruction is taken.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.instr_valid) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Register file: writeback wins over the load port; loads in WB are dropped.
   // NOTE: the register file is deliberately reset, since the reset
   // contents are architecturally visible to the first instructions.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (state_q == WB) begin
         regs_q[rd_q] <= result_q;
      end else if (bus.ld_en) begin
         regs_q[bus.ld_addr] <= bus.ld_data;
      end
   end

   // Operand issue: sources are read with pre-edge contents on accept and
   // then held until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         rd_q      <= '0;
      end else if (accept) begin
         alu_a_q   <= regs_q[rs1];
         alu_b_q   <= regs_q[rs2];
         alu_sel_q <= op;
         rd_q      <= rd;
      end
   end

   // Result capture after the ALU has had a full cycle to settle.
   always_ff @(posedge clk) begin
      if (rst)                     result_q <= '0;
      else if (state_q == CAPTURE) result_q <= bus.alu_out;
   end

   assign bus.instr_ready = !rst && (state_q == IDLE);
   assign bus.ld_ready    = !rst && (state_q != WB);
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_sel     = alu_sel_q;
   // A writeback coinciding with reset is discarded, so it is not announced.
   assign bus.wb_valid    = !rst && (state_q == WB);
   assign bus.wb_addr     = rd_q;
   assign bus.wb_data     = result_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl. A driver issues directed and
// random stimulus, keeps a cycle-level reference model of the register
// file and pushes expected writebacks; a monitor pops them whenever the
// controller announces a writeback.
module tb_alu_issue_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   cyc_ctr = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

   alu_issue_if #(.WIDTH(8)) bus ();

   alu_issue_ctrl #(.WIDTH(8), .NREGS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in ALU; op 3 returns a fixed marker value.
   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] s);
      case (s)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a ^ b;
         default: return 8'hA5;
      endcase
   endfunction

   always_comb bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      int         cyc;
   } wb_t;

   wb_t sb_q[$];

   // Reference model state.
   logic [7:0] m_regs [4];
   logic [7:0] last_a, last_b;
   logic [1:0] last_sel;
   logic       pending;
   int         acc_cyc;
   logic [1:0] m_rd;
   logic [7:0] m_res;
   logic       last_accept;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_ctr, act, exp);
      end
   endtask

   // One clock cycle of stimulus plus the model's view of the coming edge.
   task automatic step(input logic v, input logic [7:0] ins, input logic le,
                       input logic [1:0] la, input logic [7:0] ld, input logic r);
      int         c;
      int         ph;
      logic [1:0] rs1, rs2;
      @(negedge clk);
      rst             = r;
      bus.instr_valid = v;
      bus.instr       = ins;
      bus.ld_en       = le;
      bus.ld_addr     = la;
      bus.ld_data     = ld;
      #1;
      c  = cyc_ctr;
      ph = pending ? (c - acc_cyc) : 0;
      check("instr_ready", 32'(bus.instr_ready), 32'(!r && !pending));
      check("ld_ready",    32'(bus.ld_ready),    32'(!r && !(pending && ph == 3)));
      check("busy",        32'(bus.busy),        32'(pending));
      check("alu_a",       32'(bus.alu_a),       32'(last_a));
      check("alu_b",       32'(bus.alu_b),       32'(last_b));
      check("alu_sel",     32'(bus.alu_sel),     32'(last_sel));
      last_accept = 1'b0;
      if (r) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
         last_a   = 8'h00;
         last_b   = 8'h00;
         last_sel = 2'd0;
         pending  = 1'b0;
         sb_q.delete();
      end else if (pending && ph == 3) begin
         m_regs[m_rd] = m_res;
         pending      = 1'b0;
      end else begin
         if (v && !pending) begin
            rs1      = ins[3:2];
            rs2      = ins[1:0];
            m_rd     = ins[5:4];
            m_res    = alu_fn(m_regs[rs1], m_regs[rs2], ins[7:6]);
            last_a   = m_regs[rs1];
            last_b   = m_regs[rs2];
            last_sel = ins[7:6];
            sb_q.push_back('{addr: m_rd, data: m_res, cyc: c + 3});
            pending     = 1'b1;
            acc_cyc     = c;
            last_accept = 1'b1;
         end
         if (le) m_regs[la] = ld;
      end
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      step(1'b0, 8'h00, 1'b1, a, d, 1'b0);
   endtask

   task automatic issue(input logic [7:0] ins);
      step(1'b1, ins, 1'b0, 2'd0, 8'h00, 1'b0);
      repeat (3) idle();
   endtask

   // Monitor: compares every announced writeback with the scoreboard head.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.wb_valid) begin
            if (sb_q.size() == 0) begin
               check("wb_unexpected", 32'(1), 32'(0));
            end else begin
               e = sb_q.pop_front();
               check("wb_addr",  32'(bus.wb_addr), 32'(e.addr));
               check("wb_data",  32'(bus.wb_data), 32'(e.data));
               check("wb_cycle", 32'(cyc_ctr),     32'(e.cyc));
            end
         end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc_ctr) begin
            e = sb_q.pop_front();
            check("wb_missing", 32'(0), 32'(1));
         end
      end
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] cur;
      logic       want;
      int         waited;
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 8'h00;
      bus.ld_en       = 1'b0;
      bus.ld_addr     = 2'd0;
      bus.ld_data     = 8'h00;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      last_a      = 8'h00;
      last_b      = 8'h00;
      last_sel    = 2'd0;
      pending     = 1'b0;
      acc_cyc     = 0;
      m_rd        = 2'd0;
      m_res       = 8'h00;
      last_accept = 1'b0;
      repeat (3) @(posedge clk);

      // Reset then idle; registers read back as zero.
      idle();
      check("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
      check("rst_wb_addr",  32'(bus.wb_addr),  32'(0));
      check("rst_wb_data",  32'(bus.wb_data),  32'(0));
      issue(8'b00_11_01_10);
      issue(8'b00_00_11_00);

      // Load and add: r2 = 2 + 2.
      load(2'd0, 8'h02);
      load(2'd1, 8'h02);
      issue(8'b00_10_00_01);
      idle();

      // Wrap-around add and the marker op.
      load(2'd0, 8'hFF);
      load(2'd1, 8'h01);
      issue(8'b00_00_00_01);
      issue(8'b11_01_00_00);

      // Load in the writeback cycle is dropped.
      step(1'b1, 8'b01_10_01_00, 1'b0, 2'd0, 8'h00, 1'b0);
      idle();
      idle();
      step(1'b0, 8'h00, 1'b1, 2'd3, 8'h77, 1'b0);
      issue(8'b00_00_11_11);

      // Load to rs1 in the accept cycle is not seen by that instruction.
      load(2'd1, 8'h10);
      step(1'b1, 8'b00_10_01_01, 1'b1, 2'd1, 8'h33, 1'b0);
      repeat (3) idle();
      issue(8'b10_11_01_10);

      // Back-to-back with valid held; second reads the first's rd.
      step(1'b1, 8'b00_01_01_01, 1'b0, 2'd0, 8'h00, 1'b0);
      waited = 0;
      do begin
         step(1'b1, 8'b01_10_01_00, 1'b0, 2'd0, 8'h00, 1'b0);
         waited++;
      end while (!last_accept && waited < 10);
      check("b2b_accept_gap", 32'(waited), 32'(4));
      repeat (4) idle();

      // Reset during CAPTURE abandons the instruction.
      load(2'd2, 8'h11);
      step(1'b1, 8'b00_11_10_10, 1'b0, 2'd0, 8'h00, 1'b0);
      idle();
      step(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
      repeat (3) idle();
      issue(8'b00_00_11_11);

      // Randomised traffic with occasional resets.
      want = 1'b0;
      cur  = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!want && $urandom_range(0, 2) != 0) begin
            cur  = 8'($urandom);
            want = 1'b1;
         end
         step(want, cur, ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom),
              ($urandom_range(0, 99) == 0));
         if (last_accept) want = 1'b0;
      end

      repeat (6) idle();
      check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
